scfifo_param: RTL and testbench

Parametrised single-clock FIFO, the next-generation replacement for the fixed-configuration FIFO behind the standard `i_fifo` interface. It adds configurable depth, programmable almost-full/almost-empty thresholds, a selectable show-ahead or normal read mode, and optional sticky overflow/underflow error flags. It sits between any producer and consumer in the CCI datapath, and its ports map one-to-one onto the `i_fifo` signal set.

---
 rtl/scfifo_param.sv | 132 +++++++++++++
 tb/tb_scfifo_param.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/scfifo_param.sv
// Parametrised single-clock FIFO with almost-full/almost-empty flags and normal or show-ahead read.
// Define SCFIFO_PARAM_ERR_FLAGS_EN to build the sticky overflow/underflow detectors.
module scfifo_param #(
    parameter int DATA_WIDTH       = 512,
    parameter int DEPTH            = 64,
    parameter int COUNT_WIDTH      = 32,
    parameter int ALM_FULL_THRESH  = DEPTH - 4,
    parameter int ALM_EMPTY_THRESH = 4,
    parameter int SHOWAHEAD        = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   full,
    output logic                   empty,
    output logic                   alm_full,
    output logic                   alm_empty,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("scfifo_param: DEPTH must be a power of two and at least 4");
    end
    if (COUNT_WIDTH < CNT_W) begin : g_bad_count_width
        $error("scfifo_param: COUNT_WIDTH must be at least $clog2(DEPTH)+1");
    end
    if (ALM_FULL_THRESH < 1 || ALM_FULL_THRESH > DEPTH) begin : g_bad_af
        $error("scfifo_param: ALM_FULL_THRESH must lie in 1..DEPTH");
    end
    if (ALM_EMPTY_THRESH < 0 || ALM_EMPTY_THRESH > DEPTH - 1) begin : g_bad_ae
        $error("scfifo_param: ALM_EMPTY_THRESH must lie in 0..DEPTH-1");
    end
    if (SHOWAHEAD != 0 && SHOWAHEAD != 1) begin : g_bad_sa
        $error("scfifo_param: SHOWAHEAD must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, empty_q, alm_full_q, alm_empty_q;
    logic                  wr_acc, rd_acc;

    // When full only the read can go; when empty only the write can go.
    assign wr_acc = wr_en && !full_q;
    assign rd_acc = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_acc && rd_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Flags are registered from the next-state count so they never lag count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            alm_full_q  <= 1'b0;
            alm_empty_q <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= (count_d == CNT_W'(DEPTH));
            empty_q     <= (count_d == '0);
            alm_full_q  <= (count_d >= CNT_W'(ALM_FULL_THRESH));
            alm_empty_q <= (count_d <= CNT_W'(ALM_EMPTY_THRESH));
        end
    end

    always_ff @(posedge clk) begin
        if (reset && wr_acc) mem_q[wr_ptr_q] <= data_in;
    end

    if (SHOWAHEAD != 0) begin : g_showahead
        assign data_out = empty_q ? '0 : mem_q[rd_ptr_q];
    end else begin : g_normal
        logic [DATA_WIDTH-1:0] dout_q;
        always_ff @(posedge clk) begin
            if (!reset) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem_q[rd_ptr_q];
            end
        end
        assign data_out = dout_q;
    end

`ifdef SCFIFO_PARAM_ERR_FLAGS_EN
    logic overflow_q, underflow_q;
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && full_q)  overflow_q  <= 1'b1;
            if (rd_en && empty_q) underflow_q <= 1'b1;
        end
    end
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign full      = full_q;
    assign empty     = empty_q;
    assign alm_full  = alm_full_q;
    assign alm_empty = alm_empty_q;
    assign count     = COUNT_WIDTH'(count_q);

endmodule

// File: tb/tb_scfifo_param.sv
// Directed bench for scfifo_param: one normal-mode and one show-ahead instance share the stimulus.
module tb_scfifo_param;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;
`ifdef SCFIFO_PARAM_ERR_FLAGS_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout_n, dout_s;
    logic          full_n, empty_n, af_n, ae_n, ovf_n, unf_n;
    logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic [CW-1:0] count_n, count_s;

    always #5 clk = ~clk;

    scfifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(CW),
                   .ALM_FULL_THRESH(AF), .ALM_EMPTY_THRESH(AE), .SHOWAHEAD(0)) u_norm (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout_n), .full(full_n), .empty(empty_n), .alm_full(af_n),
        .alm_empty(ae_n), .count(count_n), .overflow(ovf_n), .underflow(unf_n));

    scfifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(CW),
                   .ALM_FULL_THRESH(AF), .ALM_EMPTY_THRESH(AE), .SHOWAHEAD(1)) u_sa (
        .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(dout_s), .full(full_s), .empty(empty_s), .alm_full(af_s),
        .alm_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s));

    typedef struct {
        logic          rst_n, wr, rd;
        logic [DW-1:0] din;
        int            cnt;
        logic          full, empty, af, ae;
        logic [DW-1:0] dout, sa_dout;
        logic          ovf, unf;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(input logic rst_n, wr, rd, input logic [DW-1:0] din,
                                input int cnt, input logic [DW-1:0] dout, sa_dout,
                                input logic ovf, unf);
        vec_t v;
        v.rst_n = rst_n; v.wr = wr; v.rd = rd; v.din = din; v.cnt = cnt;
        v.full  = (cnt == DEPTH);
        v.empty = (cnt == 0);
        v.af    = (cnt >= AF);
        v.ae    = (cnt <= AE);
        v.dout  = dout; v.sa_dout = sa_dout;
        v.ovf   = ovf & ERR;
        v.unf   = unf & ERR;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, wr, rd, input logic [DW-1:0] din);
        @(negedge clk);
        reset = rst_n; wr_en = wr; rd_en = rd; data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " count"},     32'(count_n), 32'(v.cnt));
        check({tag, " sa_count"},  32'(count_s), 32'(v.cnt));
        check({tag, " full"},      32'(full_n),  32'(v.full));
        check({tag, " empty"},     32'(empty_n), 32'(v.empty));
        check({tag, " sa_empty"},  32'(empty_s), 32'(v.empty));
        check({tag, " alm_full"},  32'(af_n),    32'(v.af));
        check({tag, " alm_empty"}, 32'(ae_n),    32'(v.ae));
        check({tag, " data_out"},  32'(dout_n),  32'(v.dout));
        check({tag, " sa_data"},   32'(dout_s),  32'(v.sa_dout));
        check({tag, " overflow"},  32'(ovf_n),   32'(v.ovf));
        check({tag, " underflow"}, 32'(unf_n),   32'(v.unf));
        check({tag, " sa_ovf"},    32'(ovf_s),   32'(v.ovf));
    endtask

    initial begin
        vec_t v;
        // Reset, then fill 0x0001..0x0008
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        for (int k = 1; k <= 8; k++)
            add(1, 1, 0, DW'(k), k, 16'h0000, 16'h0001, 0, 0);
        // Write+read while full: read wins, 0x00FF is dropped
        add(1, 1, 1, 16'h00FF, 7, 16'h0001, 16'h0002, 1, 0);
        for (int j = 0; j < 7; j++)
            add(1, 0, 1, 16'h0000, 6 - j, DW'(16'h0002 + j),
                (j == 6) ? 16'h0000 : DW'(16'h0003 + j), 1, 0);
        // Read while empty, then write+read while empty
        add(1, 0, 1, 16'h0000, 0, 16'h0008, 16'h0000, 1, 1);
        add(1, 1, 1, 16'h0A0A, 1, 16'h0008, 16'h0A0A, 1, 1);
        add(1, 0, 1, 16'h0000, 0, 16'h0A0A, 16'h0000, 1, 1);
        // Wrap-around: hold count=3 for 20 simultaneous read/write cycles
        for (int k = 1; k <= 3; k++)
            add(1, 1, 0, DW'(16'h0100 + k), k, 16'h0A0A, 16'h0101, 1, 1);
        for (int i = 0; i < 20; i++)
            add(1, 1, 1, DW'(16'h0104 + i), 3, DW'(16'h0101 + i), DW'(16'h0102 + i), 1, 1);
        for (int j = 0; j < 3; j++)
            add(1, 0, 1, 16'h0000, 2 - j, DW'(16'h0115 + j),
                (j == 2) ? 16'h0000 : DW'(16'h0116 + j), 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.rst_n, v.wr, v.rd, v.din);
            check_all($sformatf("v%0d", i), v);
        end

        // Reset mid-stream at count=5 while a write is requested
        for (int k = 1; k <= 5; k++) drive(1, 1, 0, DW'(16'h0200 + k));
        check("mid count5", 32'(count_n), 32'd5);
        check("mid sa_head", 32'(dout_s), 32'h0201);
        drive(0, 1, 0, 16'h0206);
        v.cnt = 0; v.full = 0; v.empty = 1; v.af = 0; v.ae = 1;
        v.dout = 16'h0000; v.sa_dout = 16'h0000; v.ovf = 0; v.unf = 0;
        check_all("rst", v);
        drive(1, 1, 0, 16'h0301);
        check("post count", 32'(count_n), 32'd1);
        check("post sa_data", 32'(dout_s), 32'h0301);
        drive(1, 0, 1, 16'h0000);
        check("post data_out", 32'(dout_n), 32'h0301);
        check("post empty", 32'(empty_n), 32'd1);
        check("post sa_data0", 32'(dout_s), 32'h0000);
        check("post overflow", 32'(ovf_n), 32'd0);

        // Overflow alone on a full FIFO, then it must survive normal traffic
        for (int k = 1; k <= 8; k++) drive(1, 1, 0, DW'(16'h0400 + k));
        check("ovf full", 32'(full_n), 32'd1);
        check("ovf pre", 32'(ovf_n), 32'd0);
        drive(1, 1, 0, 16'h04FF);
        check("ovf set", 32'(ovf_n), 32'(ERR));
        check("ovf count", 32'(count_n), 32'd8);
        drive(1, 0, 1, 16'h0000);
        drive(1, 1, 1, 16'h0409);
        check("ovf sticky", 32'(ovf_n), 32'(ERR));
        check("ovf unf", 32'(unf_n), 32'd0);
        check("ovf drain", 32'(dout_n), 32'h0402);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
